// File: rtl/ps2_kb_receiver.sv
// rtl/ps2_kb_receiver.sv - PS/2 keyboard frame receiver and make/break decoder
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN (suppresses code_valid on typematic repeats)
module ps2_kb_receiver #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] kb_code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_prev, fall;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic          parity_bit;
  logic          frame_ok, stop_good, stop_bad;
  logic          break_flag, ext_flag;

  // Two-flop synchronisers for both asynchronous pins; idle level is high
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: flip the filtered clock after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = filt_prev & ~filt_clk;

  // A fall event wins over a timeout expiring in the same cycle
  assign timeout_hit = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT - 1));

  // Timeout counter: counts mid-frame cycles since the last fall event
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || fall || timeout_hit) to_cnt <= '0;
    else                                             to_cnt <= to_cnt + TW'(1);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: advances on fall events, aborts to IDLE on timeout
  always_comb begin
    state_nxt = state;
    if (fall) begin
      case (state)
        IDLE:    if (!dat_s2) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    if (timeout_hit) state_nxt = IDLE;
  end

  // FSM outputs: frame verdict at the stop bit and the error pulse
  always_comb begin
    frame_ok  = dat_s2 & (^{shift_reg, parity_bit});
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    if (state == STOP && fall) begin
      stop_good = frame_ok;
      stop_bad  = ~frame_ok;
    end
    frame_err = ~rst & (stop_bad | timeout_hit);
  end

  // Frame datapath: LSB-first shift of data bits and parity capture
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
    end else if (fall) begin
      case (state)
        IDLE:    bit_cnt <= '0;
        DATA: begin
          shift_reg <= {dat_s2, shift_reg[7:1]};
          bit_cnt   <= bit_cnt + 3'd1;
        end
        PARITY:  parity_bit <= dat_s2;
        default: ;
      endcase
    end
  end

  // Make/break decode of completed frames into the held-key code
  always_ff @(posedge clk) begin
    if (rst) begin
      kb_code    <= 8'h00;
      code_valid <= 1'b0;
      break_flag <= 1'b0;
      ext_flag   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      ext_flag   <= ext_flag;
      if (stop_bad) begin
        break_flag <= 1'b0;
        ext_flag   <= 1'b0;
      end else if (stop_good) begin
        if (shift_reg == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (shift_reg == 8'hF0) begin
          break_flag <= 1'b1;
        end else if (break_flag) begin
          if (shift_reg == kb_code) kb_code <= 8'h00;
          break_flag <= 1'b0;
          ext_flag   <= 1'b0;
        end else begin
          ext_flag <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (!(shift_reg == kb_code && kb_code != 8'h00)) begin
            kb_code    <= shift_reg;
            code_valid <= 1'b1;
          end
`else
          kb_code    <= shift_reg;
          code_valid <= 1'b1;
`endif
        end
      end
    end
  end

endmodule
